i2c_master_write_byte: RTL
==========================

// Module: i2c_master_write_byte
// PURPOSE
//   Byte-level sequencer directly upstream of I2C_master_write_bit. Takes one data
//   byte with optional START/STOP framing from the transaction controller.
//   Issues the matching series of bit commands over the go/command/finish handshake.
//   Owns no bus pins; scl/sda stay with the bit-level writer.
// PARAMETERS
//   CMD_START  3'b010  bit command: START condition
//   CMD_STOP   3'b011  bit command: STOP condition
//   CMD_DATA0  3'b100  bit command: drive data 0
//   CMD_DATA1  3'b101  bit command: drive data 1
// PORTS
//   clock        in   1  system clock, all logic on rising edge
//   reset_n      in   1  synchronous active-low reset
//   go           in   1  request from controller; held high until finish seen
//   data_in      in   8  byte to send, MSB first; sampled with go
//   with_start   in   1  prepend CMD_START; sampled with go
//   with_stop    in   1  append CMD_STOP; sampled with go
//   finish       out  1  sequence complete; held until go low
//   bit_go       out  1  request to bit writer
//   bit_command  out  3  command to bit writer; stable while bit_go high
//   bit_finish   in   1  completion from bit writer
// BEHAVIOUR
//   Reset: state=IDLE; finish=0, bit_go=0, bit_command=3'b000, step counter=0, latches cleared.
//   All outputs registered; reset takes effect at the next clock edge, including mid-sequence.
//   Sequence: [CMD_START if with_start], data_in[7]..data_in[0] as DATA1/DATA0, [CMD_STOP if with_stop].
//     Length 8..10 commands; 4-bit step counter; no wrap past final step.
//   FSM:
//     IDLE    : go=1 and finish=0 -> latch data_in/with_start/with_stop, load first cmd, ISSUE.
//               bit_finish ignored here.
//     ISSUE   : bit_go=1, bit_command=current step; bit_finish=1 -> bit_go=0 next edge, RELEASE.
//     RELEASE : bit_go=0; wait bit_finish=0; then more steps -> advance, load cmd, ISSUE;
//               last step -> DONE.
//     DONE    : finish=1; go=0 sampled -> finish=0, IDLE.
//   Latency: bit_go rises 1 cycle after go is sampled high.
//     Never two bit_go pulses without bit_finish seen low between them.
//   Inputs changing while busy are ignored; latched copies are used.
//   go dropping mid-sequence does not cancel; sequence completes and finish is high >=1 cycle.
//   bit_finish high in the same cycle bit_go rises is legal and counts as completion.
//   with_start=0, with_stop=0 -> exactly 8 data commands.
// CONFIGURATION
//   I2C_WRITE_BYTE_ABORT_EN defined:
//     - Adds input abort (1 bit) and output aborted (1 bit, reset 0).
//     - abort=1 in ISSUE/RELEASE: current bit command completes normally.
//     - Then CMD_STOP is issued (even if with_stop=0), then DONE with aborted=1.
//     - aborted clears together with finish.
//     - abort in IDLE/DONE is ignored.
//   I2C_WRITE_BYTE_ABORT_EN undefined: no abort/aborted ports; sequence always runs to completion.
// TESTING
//   Bench model: bit-writer responder; asserts bit_finish 3 cycles after bit_go and drops it
//   1 cycle after bit_go falls.
//   1. Reset 2 cycles, go=1, data_in=8'hA5, start=1, stop=1
//      -> commands 010,101,100,101,100,100,101,100,101,011; finish=1; go=0 -> finish=0 next cycle.
//   2. data_in=8'h00, start=0, stop=0
//      -> exactly 8 commands of 100, no 010/011; finish after 8th completion.
//   3. Back-to-back: go held across finish, data_in=8'hFF then 8'h3C
//      -> second byte not started until go low then high; 8x101 then 100,100,101,101,101,101,100,100.
//   4. Change data_in to 8'h00 during bit 3 of 8'hF0 -> 8'hF0 still sent.
//   5. reset_n=0 during 4th command -> bit_go=0, finish=0 next edge; new go restarts from step 0.
//   6. (ABORT_EN) abort=1 during bit 2 of 8'h81
//      -> bit 2 completes, 011 issued, finish=1 with aborted=1.

Source files
------------

// File: rtl/i2c_master_write_byte.sv
// Byte-level I2C write sequencer: turns one byte plus optional START/STOP into bit commands.
// Optional abort support is compiled in with `define I2C_WRITE_BYTE_ABORT_EN.
module i2c_master_write_byte (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       go,
    input  logic [7:0] data_in,
    input  logic       with_start,
    input  logic       with_stop,
`ifdef I2C_WRITE_BYTE_ABORT_EN
    input  logic       abort,
    output logic       aborted,
`endif
    output logic       finish,
    output logic       bit_go,
    output logic [2:0] bit_command,
    input  logic       bit_finish
);

    localparam logic [2:0] CMD_START = 3'b010;
    localparam logic [2:0] CMD_STOP  = 3'b011;
    localparam logic [2:0] CMD_DATA0 = 3'b100;
    localparam logic [2:0] CMD_DATA1 = 3'b101;

    typedef enum logic [1:0] {StIdle, StIssue, StRelease, StDone} state_e;

    state_e     state_q, state_d;
    logic [3:0] step_q, step_d;
    logic [7:0] data_q, data_d;
    logic       start_q, start_d;
    logic       stop_q, stop_d;
    logic       finish_q, finish_d;
    logic       bit_go_q, bit_go_d;
    logic [2:0] cmd_q, cmd_d;
    logic [3:0] last_step;
`ifdef I2C_WRITE_BYTE_ABORT_EN
    logic       abort_pend_q, abort_pend_d;
    logic       aborted_q, aborted_d;
    logic       abort_now;
`endif

    // Step index -> command; the STOP slot is only reachable when stop is latched.
    function automatic logic [2:0] cmd_at(input logic [3:0] step, input logic [7:0] d,
                                          input logic s);
        logic [3:0] idx;
        idx = step - {3'b000, s};
        if (s && step == 4'd0) begin
            return CMD_START;
        end else if (idx < 4'd8) begin
            return d[3'd7 - idx[2:0]] ? CMD_DATA1 : CMD_DATA0;
        end else begin
            return CMD_STOP;
        end
    endfunction

    assign last_step = 4'd7 + {3'b000, start_q} + {3'b000, stop_q};

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        data_d   = data_q;
        start_d  = start_q;
        stop_d   = stop_q;
        finish_d = finish_q;
        bit_go_d = bit_go_q;
        cmd_d    = cmd_q;
`ifdef I2C_WRITE_BYTE_ABORT_EN
        abort_pend_d = abort_pend_q;
        aborted_d    = aborted_q;
        abort_now    = abort_pend_q | abort;
`endif
        unique case (state_q)
            StIdle: begin
                if (go && !finish_q) begin
                    data_d   = data_in;
                    start_d  = with_start;
                    stop_d   = with_stop;
                    step_d   = 4'd0;
                    cmd_d    = cmd_at(4'd0, data_in, with_start);
                    bit_go_d = 1'b1;
                    state_d  = StIssue;
`ifdef I2C_WRITE_BYTE_ABORT_EN
                    abort_pend_d = 1'b0;
`endif
                end
            end
            StIssue: begin
`ifdef I2C_WRITE_BYTE_ABORT_EN
                if (abort) abort_pend_d = 1'b1;
`endif
                if (bit_finish) begin
                    bit_go_d = 1'b0;
                    state_d  = StRelease;
                end
            end
            StRelease: begin
`ifdef I2C_WRITE_BYTE_ABORT_EN
                if (abort) abort_pend_d = 1'b1;
`endif
                if (!bit_finish) begin
`ifdef I2C_WRITE_BYTE_ABORT_EN
                    // An abort always finishes with exactly one STOP on the bus.
                    if (abort_now) begin
                        if (cmd_q != CMD_STOP) begin
                            cmd_d    = CMD_STOP;
                            bit_go_d = 1'b1;
                            state_d  = StIssue;
                        end else begin
                            finish_d  = 1'b1;
                            aborted_d = 1'b1;
                            state_d   = StDone;
                        end
                    end else
`endif
                    begin
                        if (step_q == last_step) begin
                            finish_d = 1'b1;
                            state_d  = StDone;
                        end else begin
                            step_d   = step_q + 4'd1;
                            cmd_d    = cmd_at(step_q + 4'd1, data_q, start_q);
                            bit_go_d = 1'b1;
                            state_d  = StIssue;
                        end
                    end
                end
            end
            StDone: begin
                finish_d = 1'b1;
                if (!go) begin
                    finish_d = 1'b0;
                    state_d  = StIdle;
`ifdef I2C_WRITE_BYTE_ABORT_EN
                    aborted_d = 1'b0;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            step_q   <= 4'd0;
            data_q   <= 8'd0;
            start_q  <= 1'b0;
            stop_q   <= 1'b0;
            finish_q <= 1'b0;
            bit_go_q <= 1'b0;
            cmd_q    <= 3'b000;
`ifdef I2C_WRITE_BYTE_ABORT_EN
            abort_pend_q <= 1'b0;
            aborted_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            data_q   <= data_d;
            start_q  <= start_d;
            stop_q   <= stop_d;
            finish_q <= finish_d;
            bit_go_q <= bit_go_d;
            cmd_q    <= cmd_d;
`ifdef I2C_WRITE_BYTE_ABORT_EN
            abort_pend_q <= abort_pend_d;
            aborted_q    <= aborted_d;
`endif
        end
    end

    assign finish      = finish_q;
    assign bit_go      = bit_go_q;
    assign bit_command = cmd_q;
`ifdef I2C_WRITE_BYTE_ABORT_EN
    assign aborted     = aborted_q;
`endif

endmodule
